// File: rtl/player_input_capture.sv
// player_input_capture
//
// Controller-input front end for the register bank's player-input word.
// Each raw button line is optionally inverted, then synchronised into clk
// and debounced on its own channel. The block keeps two bitmaps: the
// debounced level, and sticky press-event bits that hold until the
// datapath reads the word. An overflow flag records a press that arrived
// while the same button's previous press was still unread.
//
// Ports:
//   clk           in  1        sole clock, rising edge
//   reset         in  1        asynchronous, active-high; clears all state
//   btn_in        in  NUM_BTN  raw asynchronous button lines
//   rd_strobe     in  1        one-cycle pulse: word sampled, clear events
//   player_word   out DATA_W   {overflow, zeros, sticky, level}
//   level         out NUM_BTN  debounced pressed state
//   event_pending out 1        OR of all sticky bits
//
// Parameter limits: 1 <= NUM_BTN <= (DATA_W-1)/2, SYNC_STAGES >= 2,
// DEBOUNCE_CYCLES >= 1.

module player_input_capture #(
    parameter int NUM_BTN         = 4,
    parameter int DATA_W          = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn_in,
    input  logic                rd_strobe,
    output logic [DATA_W-1:0]   player_word,
    output logic [NUM_BTN-1:0]  level,
    output logic                event_pending
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } db_state_e;

    // Pressed-is-1 view of the pins, taken before the synchroniser.
    logic [NUM_BTN-1:0] pol_in;
    assign pol_in = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    // ------------------------------------------------------------------
    // Synchroniser: stage 0 samples the pins, the last stage feeds debounce.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the synchroniser is a small register array, not RAM, so
            // it is reset in a loop; an inferred memory would be left
            // unreset instead.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pol_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce, event and overflow state.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    db_state_e          state [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] sticky_q, sticky_d;
    logic [NUM_BTN-1:0] rise;
    logic               overflow_q, overflow_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            level_q    <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q    <= level_d;
            sticky_q   <= sticky_d;
            overflow_q <= overflow_d;
        end
    end

    // The FSM state is the agreement between the synchronised pin and the
    // accepted level; the count only runs while they disagree.
    always_comb begin
        // NOTE: every output of this block gets a default before any
        // branch, so no path can leave a value unassigned and infer a latch.
        level_d = level_q;
        rise    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            state[i] = (sync[i] == level_q[i]) ? STABLE : CHANGING;
            case (state[i])
                STABLE: begin
                    cnt_d[i] = '0;
                end
                CHANGING: begin
                    if (cnt_q[i] == CNT_LAST) begin
                        // Commit: the press event comes from the commit
                        // itself, so it lands on the same edge as level.
                        level_d[i] = sync[i];
                        rise[i]    = sync[i];
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_d[i] = '0;
                end
            endcase
        end

        // A rise on the read edge survives the clear.
        sticky_d = (sticky_q & ~{NUM_BTN{rd_strobe}}) | rise;

        // A read clears the flag; a lost press can only be recorded when
        // no read happens on the same edge.
        if (rd_strobe) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q | (|(rise & sticky_q));
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure functions of registers.
    // ------------------------------------------------------------------
    always_comb begin
        player_word                      = '0;
        player_word[NUM_BTN-1:0]         = level_q;
        player_word[2*NUM_BTN-1:NUM_BTN] = sticky_q;
        player_word[DATA_W-1]            = overflow_q;
    end

    assign level         = level_q;
    assign event_pending = |sticky_q;

endmodule

// File: tb/tb_player_input_capture.sv
// Directed bench for player_input_capture with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, NUM_BTN=4, DATA_W=16. A second instance with
// ACTIVE_LOW=1 shares clock and reset. Inputs are driven 1 time unit after
// a rising edge; outputs are sampled at the same point.

module tb_player_input_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  btn_in;
    logic        rd_strobe;
    logic [15:0] player_word;
    logic [3:0]  level;
    logic        event_pending;

    logic [3:0]  btn_lo;
    logic        rd_lo;
    logic [15:0] word_lo;
    logic [3:0]  level_lo;
    logic        pend_lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    player_input_capture #(
        .NUM_BTN(4), .DATA_W(16), .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .rd_strobe(rd_strobe),
        .player_word(player_word), .level(level), .event_pending(event_pending)
    );

    player_input_capture #(
        .NUM_BTN(4), .DATA_W(16), .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)
    ) dut_lo (
        .clk(clk), .reset(reset), .btn_in(btn_lo), .rd_strobe(rd_lo),
        .player_word(word_lo), .level(level_lo), .event_pending(pend_lo)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe();
        rd_strobe = 1'b1;
        tick(1);
        rd_strobe = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        btn_in    = 4'h0;
        rd_strobe = 1'b0;
        btn_lo    = 4'hF;
        rd_lo     = 1'b0;
        tick(2);
        check("reset_word", 32'(player_word), 32'h0000);
        check("reset_level", 32'(level), 32'h0);
        check("reset_pending", 32'(event_pending), 32'h0);
        check("lo_idle_level", 32'(level_lo), 32'h0);

        // Partial count, then reset mid-count.
        reset  = 1'b0;
        btn_in = 4'hF;
        tick(3);
        reset = 1'b1;
        tick(3);
        check("midcount_reset_word", 32'(player_word), 32'h0000);
        check("midcount_reset_pend", 32'(event_pending), 32'h0);
        reset = 1'b0;
        tick(5);
        check("held_thru_reset_e5", 32'(player_word), 32'h0000);
        tick(1);
        check("held_thru_reset_e6", 32'(player_word), 32'h00FF);
        check("held_thru_reset_lvl", 32'(level), 32'hF);
        check("held_thru_reset_pend", 32'(event_pending), 32'h1);
        strobe();
        check("strobe_clears_all", 32'(player_word), 32'h000F);
        btn_in = 4'h0;
        tick(6);
        check("release_no_event", 32'(player_word), 32'h0000);

        // Single press on channel 0.
        btn_in = 4'h1;
        tick(5);
        check("press_e5", 32'(player_word), 32'h0000);
        tick(1);
        check("press_e6", 32'(player_word), 32'h0011);
        strobe();
        check("press_read", 32'(player_word), 32'h0001);
        check("press_read_pend", 32'(event_pending), 32'h0);

        // Glitch on channel 2: 3 cycles high is rejected.
        btn_in = 4'h5;
        tick(3);
        btn_in = 4'h1;
        tick(8);
        check("glitch_reject", 32'(player_word), 32'h0001);
        // 4-cycle pulse commits, then its release commits too.
        btn_in = 4'h5;
        tick(4);
        btn_in = 4'h1;
        tick(2);
        check("pulse4_commit", 32'(player_word), 32'h0045);
        tick(6);
        check("pulse4_release", 32'(player_word), 32'h0041);
        strobe();
        check("pulse4_read", 32'(player_word), 32'h0001);

        // Set/clear collision: re-arm sticky[0], then read on bit-1 commit.
        btn_in = 4'h0;
        tick(6);
        check("all_released", 32'(player_word), 32'h0000);
        btn_in = 4'h1;
        tick(6);
        check("rearm_bit0", 32'(player_word), 32'h0011);
        btn_in = 4'h3;
        tick(5);
        rd_strobe = 1'b1;
        tick(1);
        rd_strobe = 1'b0;
        check("collision", 32'(player_word), 32'h0023);

        // Overflow with btn[3] still held at the read.
        btn_in = 4'h0;
        tick(6);
        strobe();
        check("ovf_prep", 32'(player_word), 32'h0000);
        btn_in = 4'h8;
        tick(6);
        check("ovf_press1", 32'(player_word), 32'h0088);
        btn_in = 4'h0;
        tick(6);
        check("ovf_release1", 32'(player_word), 32'h0080);
        btn_in = 4'h8;
        tick(6);
        check("ovf_press2", 32'(player_word), 32'h8088);
        strobe();
        check("ovf_read_held", 32'(player_word), 32'h0008);

        // Overflow with btn[3] released before the read.
        btn_in = 4'h0;
        tick(6);
        check("ovf2_idle", 32'(player_word), 32'h0000);
        btn_in = 4'h8;
        tick(6);
        btn_in = 4'h0;
        tick(6);
        btn_in = 4'h8;
        tick(6);
        check("ovf2_press2", 32'(player_word), 32'h8088);
        btn_in = 4'h0;
        tick(6);
        check("ovf2_released", 32'(player_word), 32'h8080);
        strobe();
        check("ovf2_read", 32'(player_word), 32'h0000);

        // rd_strobe held high: only the same-edge rise survives.
        rd_strobe = 1'b1;
        btn_in    = 4'h4;
        tick(6);
        check("held_rd_commit", 32'(player_word), 32'h0044);
        tick(1);
        check("held_rd_clears", 32'(player_word), 32'h0004);
        rd_strobe = 1'b0;

        // Active-low instance: pull pin 1 low.
        btn_lo = 4'hD;
        tick(5);
        check("lo_press_e5", 32'(level_lo), 32'h0);
        tick(1);
        check("lo_press_e6", 32'(level_lo), 32'h2);
        check("lo_press_word", 32'(word_lo), 32'h0022);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
